// File: rtl/posit_mult_4_0_arbiter.sv
// posit_mult_4_0_arbiter
//   Shares one posit<4,0> multiplier between N_REQ requesters. Requesters
//   are served round-robin. Each pair goes through two pipeline stages:
//   S1 holds the operands and S2 is the output register. One global advance
//   signal stalls both stages together, so bubbles are not collapsed.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    per-requester handshake (N_REQ bits each)
//   fraction_i1/2            per-requester fraction bit of operand 1/2
//   scale_i1/2               per-requester signed scale, bits [4i+3:4i]
//   NaR/zero/sign_i1/2       per-requester operand flags
//   res_valid / res_ready    result handshake
//   res_id                   index of the requester that owns the result
//   fraction_o, scale_o      denormalized product
//   NaR_o, sign_o, zero_o    product flags, not resolved here
//   busy                     a pipeline stage holds valid data

// posit_mult_4_0
//   Combinational multiplier for decoded posit<4,0> operands. The result is
//   left denormalized for the consumer to handle.
//
// Ports
//   f1, f2        fraction bits
//   s1, s2        signed scales
//   n1..g2        NaR / zero / sign flags of each operand
//   fraction      product fraction: [3] = f1^f2, [1] = f1&f2
//   scale         s1 + s2 + fraction[3], wraps at 4 bits
//   nar, sign, zero  product flags
module posit_mult_4_0 (
   input  logic              f1,
   input  logic              f2,
   input  logic signed [3:0] s1,
   input  logic signed [3:0] s2,
   input  logic              n1,
   input  logic              z1,
   input  logic              g1,
   input  logic              n2,
   input  logic              z2,
   input  logic              g2,
   output logic [3:0]        fraction,
   output logic signed [3:0] scale,
   output logic              nar,
   output logic              sign,
   output logic              zero
);

   logic carry;

   // (1+f1/2)(1+f2/2) = 1 + (f1+f2)/2 + f1f2/4. When exactly one fraction
   // bit is set, the product is shown as a bump in scale plus the half bit.
   assign carry    = f1 ^ f2;
   assign fraction = {carry, 1'b0, f1 & f2, 1'b0};
   assign scale    = s1 + s2 + $signed({3'b000, carry});
   assign sign     = g1 ^ g2;
   assign zero     = z1 | z2;
   assign nar      = n1 | n2;

endmodule

module posit_mult_4_0_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [N_REQ-1:0]     fraction_i1,
   input  logic [N_REQ-1:0]     fraction_i2,
   input  logic [4*N_REQ-1:0]   scale_i1,
   input  logic [4*N_REQ-1:0]   scale_i2,
   input  logic [N_REQ-1:0]     NaR_i1,
   input  logic [N_REQ-1:0]     zero_i1,
   input  logic [N_REQ-1:0]     sign_i1,
   input  logic [N_REQ-1:0]     NaR_i2,
   input  logic [N_REQ-1:0]     zero_i2,
   input  logic [N_REQ-1:0]     sign_i2,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [ID_W-1:0]      res_id,
   output logic [3:0]           fraction_o,
   output logic signed [3:0]    scale_o,
   output logic                 NaR_o,
   output logic                 sign_o,
   output logic                 zero_o,
   output logic                 busy
);

   // arbitration state
   logic [ID_W-1:0]  ptr;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_id;
   logic             adv;
   logic             xfer;

   // operands picked from the granted requester
   logic             sel_f1;
   logic             sel_f2;
   logic [3:0]       sel_s1;
   logic [3:0]       sel_s2;
   logic             sel_n1;
   logic             sel_z1;
   logic             sel_g1;
   logic             sel_n2;
   logic             sel_z2;
   logic             sel_g2;

   // S1: operand register
   logic             s1_valid;
   logic [ID_W-1:0]  s1_id;
   logic             s1_f1;
   logic             s1_f2;
   logic [3:0]       s1_sc1;
   logic [3:0]       s1_sc2;
   logic             s1_n1;
   logic             s1_z1;
   logic             s1_g1;
   logic             s1_n2;
   logic             s1_z2;
   logic             s1_g2;

   // multiplier outputs
   logic [3:0]        m_fraction;
   logic signed [3:0] m_scale;
   logic              m_nar;
   logic              m_sign;
   logic              m_zero;

   // S2: output register
   logic              s2_valid;
   logic [ID_W-1:0]   s2_id;
   logic [3:0]        s2_fraction;
   logic signed [3:0] s2_scale;
   logic              s2_nar;
   logic              s2_sign;
   logic              s2_zero;

   assign adv = !s2_valid || res_ready;

   // Round-robin search starting one past the last granted requester.
   always_comb begin
      int  idx;
      logic found;
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int off = 1; off <= N_REQ; off++) begin
         idx = (int'(ptr) + off) % N_REQ;
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = ID_W'(idx);
         end
      end
   end

   // Gated by rst so no requester sees a handshake while reset is held.
   assign req_ready = rst ? '0 : (grant & {N_REQ{adv}});
   assign xfer      = |req_ready;

   // grant is one-hot, so a priority-free select is enough.
   always_comb begin
      sel_f1 = 1'b0;
      sel_f2 = 1'b0;
      sel_s1 = '0;
      sel_s2 = '0;
      sel_n1 = 1'b0;
      sel_z1 = 1'b0;
      sel_g1 = 1'b0;
      sel_n2 = 1'b0;
      sel_z2 = 1'b0;
      sel_g2 = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_f1 = fraction_i1[i];
            sel_f2 = fraction_i2[i];
            sel_s1 = scale_i1[4*i +: 4];
            sel_s2 = scale_i2[4*i +: 4];
            sel_n1 = NaR_i1[i];
            sel_z1 = zero_i1[i];
            sel_g1 = sign_i1[i];
            sel_n2 = NaR_i2[i];
            sel_z2 = zero_i2[i];
            sel_g2 = sign_i2[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= ID_W'(N_REQ - 1);
      end else if (xfer) begin
         ptr <= grant_id;
      end
   end

   // S1 reloads on every advance; with no grant it takes a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         s1_f1    <= 1'b0;
         s1_f2    <= 1'b0;
         s1_sc1   <= '0;
         s1_sc2   <= '0;
         s1_n1    <= 1'b0;
         s1_z1    <= 1'b0;
         s1_g1    <= 1'b0;
         s1_n2    <= 1'b0;
         s1_z2    <= 1'b0;
         s1_g2    <= 1'b0;
      end else if (adv) begin
         s1_valid <= xfer;
         s1_id    <= grant_id;
         s1_f1    <= sel_f1;
         s1_f2    <= sel_f2;
         s1_sc1   <= sel_s1;
         s1_sc2   <= sel_s2;
         s1_n1    <= sel_n1;
         s1_z1    <= sel_z1;
         s1_g1    <= sel_g1;
         s1_n2    <= sel_n2;
         s1_z2    <= sel_z2;
         s1_g2    <= sel_g2;
      end
   end

   posit_mult_4_0 u_mult (
      .f1       (s1_f1),
      .f2       (s1_f2),
      .s1       (s1_sc1),
      .s2       (s1_sc2),
      .n1       (s1_n1),
      .z1       (s1_z1),
      .g1       (s1_g1),
      .n2       (s1_n2),
      .z2       (s1_z2),
      .g2       (s1_g2),
      .fraction (m_fraction),
      .scale    (m_scale),
      .nar      (m_nar),
      .sign     (m_sign),
      .zero     (m_zero)
   );

   // The S2 data only loads for real results, so the outputs stay quiet
   // while bubbles pass through.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid    <= 1'b0;
         s2_id       <= '0;
         s2_fraction <= '0;
         s2_scale    <= '0;
         s2_nar      <= 1'b0;
         s2_sign     <= 1'b0;
         s2_zero     <= 1'b0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_id       <= s1_id;
            s2_fraction <= m_fraction;
            s2_scale    <= m_scale;
            s2_nar      <= m_nar;
            s2_sign     <= m_sign;
            s2_zero     <= m_zero;
         end
      end
   end

   assign res_valid  = s2_valid;
   assign res_id     = s2_id;
   assign fraction_o = s2_fraction;
   assign scale_o    = s2_scale;
   assign NaR_o      = s2_nar;
   assign sign_o     = s2_sign;
   assign zero_o     = s2_zero;
   assign busy       = s1_valid | s2_valid;

endmodule

// File: tb/tb_posit_mult_4_0_arbiter.sv
module tb_posit_mult_4_0_arbiter;

   localparam int N = 4;

   logic                clk;
   logic                rst;
   logic [N-1:0]        req_valid;
   logic [N-1:0]        req_ready;
   logic [N-1:0]        fraction_i1;
   logic [N-1:0]        fraction_i2;
   logic [4*N-1:0]      scale_i1;
   logic [4*N-1:0]      scale_i2;
   logic [N-1:0]        NaR_i1;
   logic [N-1:0]        zero_i1;
   logic [N-1:0]        sign_i1;
   logic [N-1:0]        NaR_i2;
   logic [N-1:0]        zero_i2;
   logic [N-1:0]        sign_i2;
   logic                res_valid;
   logic                res_ready;
   logic [1:0]          res_id;
   logic [3:0]          fraction_o;
   logic signed [3:0]   scale_o;
   logic                NaR_o;
   logic                sign_o;
   logic                zero_o;
   logic                busy;

   int checks = 0;
   int errors = 0;

   // {res_id, fraction_o, scale_o, NaR_o, sign_o, zero_o}
   logic [12:0] got;
   assign got = {res_id, fraction_o, scale_o, NaR_o, sign_o, zero_o};

   posit_mult_4_0_arbiter #(.N_REQ(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .fraction_i1 (fraction_i1),
      .fraction_i2 (fraction_i2),
      .scale_i1    (scale_i1),
      .scale_i2    (scale_i2),
      .NaR_i1      (NaR_i1),
      .zero_i1     (zero_i1),
      .sign_i1     (sign_i1),
      .NaR_i2      (NaR_i2),
      .zero_i2     (zero_i2),
      .sign_i2     (sign_i2),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_id      (res_id),
      .fraction_o  (fraction_o),
      .scale_o     (scale_o),
      .NaR_o       (NaR_o),
      .sign_o      (sign_o),
      .zero_o      (zero_o),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      req_valid   = '0;
      fraction_i1 = '0;
      fraction_i2 = '0;
      scale_i1    = '0;
      scale_i2    = '0;
      NaR_i1      = '0;
      zero_i1     = '0;
      sign_i1     = '0;
      NaR_i2      = '0;
      zero_i2     = '0;
      sign_i2     = '0;
   endtask

   // flags = {n1, z1, g1, n2, z2, g2}
   task automatic set_req(input int i, input logic f1, input logic [3:0] s1,
                          input logic f2, input logic [3:0] s2, input logic [5:0] flags);
      fraction_i1[i]     = f1;
      fraction_i2[i]     = f2;
      scale_i1[4*i +: 4] = s1;
      scale_i2[4*i +: 4] = s2;
      NaR_i1[i]          = flags[5];
      zero_i1[i]         = flags[4];
      sign_i1[i]         = flags[3];
      NaR_i2[i]          = flags[2];
      zero_i2[i]         = flags[1];
      sign_i2[i]         = flags[0];
   endtask

   task automatic test_reset();
      clear_all();
      res_ready = 1'b1;
      rst       = 1'b1;
      set_req(1, 1'b1, 4'd3, 1'b1, 4'd2, 6'b111111);
      req_valid = 4'hF;
      #1;
      checks++;
      if ({res_valid, busy, req_ready} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got valid/busy/ready=%b required 000000", {res_valid, busy, req_ready});
      end
      checks++;
      if (got !== 13'b0) begin
         errors++;
         $display("FAIL reset_data: got %h required 0", got);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_all();
      tick();
   endtask

   // One isolated pair through the pipe; exp is the expected 'got' vector.
   task automatic run_one(input string name, input int id, input logic f1, input logic [3:0] s1,
                          input logic f2, input logic [3:0] s2, input logic [5:0] flags,
                          input logic [12:0] exp);
      clear_all();
      res_ready = 1'b1;
      set_req(id, f1, s1, f2, s2, flags);
      req_valid[id] = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'(1 << id)) begin
         errors++;
         $display("FAIL %s_ready: got %b required %b", name, req_ready, 4'(1 << id));
      end
      tick();
      req_valid = '0;
      #1;
      checks++;
      if ({res_valid, busy} !== 2'b01) begin
         errors++;
         $display("FAIL %s_latency: got valid/busy=%b required 01", name, {res_valid, busy});
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || got !== exp) begin
         errors++;
         $display("FAIL %s_result: got valid=%b data=%h required valid=1 data=%h", name, res_valid, got, exp);
      end
      tick();
      checks++;
      if ({res_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL %s_drain: got valid/busy=%b required 00", name, {res_valid, busy});
      end
   endtask

   task automatic test_single();
      // 2 + (-1) + 1 = 2, fraction 1000, sign 1
      run_one("single", 0, 1'b1, 4'd2, 1'b0, 4'hF, 6'b001000, {2'd0, 4'b1000, 4'd2, 3'b010});
   endtask

   task automatic test_both_fractions();
      run_one("bothfrac", 2, 1'b1, 4'd0, 1'b1, 4'd0, 6'b000000, {2'd2, 4'b0010, 4'd0, 3'b000});
   endtask

   task automatic test_scale_wrap();
      // 7 + 7 + 1 = 15 -> 4'b1111
      run_one("wrap", 1, 1'b1, 4'd7, 1'b0, 4'd7, 6'b000000, {2'd1, 4'b1000, 4'b1111, 3'b000});
   endtask

   task automatic test_flags();
      // zero flag with 3 + 2 + 0 = 5, fraction 0010
      run_one("zero", 3, 1'b1, 4'd3, 1'b1, 4'd2, 6'b010000, {2'd3, 4'b0010, 4'd5, 3'b001});
      // NaR flag with -8 + -1 + 1 = -8, sign from operand 2
      run_one("nar", 3, 1'b0, 4'h8, 1'b1, 4'hF, 6'b000101, {2'd3, 4'b1000, 4'h8, 3'b110});
   endtask

   task automatic test_round_robin();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_all();
      res_ready = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'(i), 1'b0, 4'd0, 6'b000000);
      req_valid = 4'hF;
      for (int c = 0; c < 10; c++) begin
         if (c == 8) req_valid = '0;
         #1;
         checks++;
         if (req_ready !== ((c < 8) ? 4'(1 << (c % 4)) : 4'b0)) begin
            errors++;
            $display("FAIL rr_grant c=%0d: got %b required %b", c, req_ready,
                     (c < 8) ? 4'(1 << (c % 4)) : 4'b0);
         end
         checks++;
         if (c >= 2) begin
            if (res_valid !== 1'b1 || got !== {2'((c - 2) % 4), 4'b0, 4'((c - 2) % 4), 3'b000}) begin
               errors++;
               $display("FAIL rr_result c=%0d: got valid=%b data=%h required id=%0d", c, res_valid, got, (c - 2) % 4);
            end
         end else if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_result c=%0d: got valid=%b required 0", c, res_valid);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_backpressure_reset();
      // ptr is 3 after the round-robin test; requester data still scale=i
      req_valid = 4'hF;
      res_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL bp_fill0: got %b required 0001", req_ready);
      end
      tick();
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL bp_fill1: got %b required 0010", req_ready);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
         res_ready = 1'b0;
         #1;
         checks++;
         if (req_ready !== 4'b0 || res_valid !== 1'b1 || got !== {2'd0, 4'b0, 4'd0, 3'b000}) begin
            errors++;
            $display("FAIL bp_stall k=%0d: got ready=%b valid=%b data=%h required ready=0000 valid=1 id=0",
                     k, req_ready, res_valid, got);
         end
         tick();
      end
      res_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0100 || res_valid !== 1'b1 || got !== {2'd0, 4'b0, 4'd0, 3'b000}) begin
         errors++;
         $display("FAIL bp_release: got ready=%b valid=%b data=%h required ready=0100 id=0", req_ready, res_valid, got);
      end
      tick();
      req_valid = '0;
      #1;
      checks++;
      if (req_ready !== 4'b0 || res_valid !== 1'b1 || got !== {2'd1, 4'b0, 4'd1, 3'b000}) begin
         errors++;
         $display("FAIL bp_next1: got ready=%b valid=%b data=%h required id=1", req_ready, res_valid, got);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || busy !== 1'b1 || got !== {2'd2, 4'b0, 4'd2, 3'b000}) begin
         errors++;
         $display("FAIL bp_next2: got valid=%b busy=%b data=%h required id=2", res_valid, busy, got);
      end
      tick();
      checks++;
      if ({res_valid, busy} !== 2'b00) begin
         errors++;
         $display("FAIL bp_empty: got valid/busy=%b required 00", {res_valid, busy});
      end

      // refill from ptr=2: requester 3 then 0, leaving S1 and S2 both valid
      req_valid = 4'hF;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("FAIL rst_fill0: got %b required 1000", req_ready);
      end
      tick();
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rst_fill1: got %b required 0001", req_ready);
      end
      tick();
      checks++;
      if ({res_valid, busy} !== 2'b11 || res_id !== 2'd3) begin
         errors++;
         $display("FAIL rst_full: got valid/busy=%b id=%0d required 11 id=3", {res_valid, busy}, res_id);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({res_valid, busy, req_ready} !== 6'b0) begin
         errors++;
         $display("FAIL rst_async: got valid/busy/ready=%b required 000000", {res_valid, busy, req_ready});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rst_first_grant: got %b required 0001", req_ready);
      end
      tick();
      req_valid = '0;
      #1;
      checks++;
      if ({res_valid, busy} !== 2'b01) begin
         errors++;
         $display("FAIL rst_no_stale: got valid/busy=%b required 01", {res_valid, busy});
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || got !== {2'd0, 4'b0, 4'd0, 3'b000}) begin
         errors++;
         $display("FAIL rst_result: got valid=%b data=%h required id=0", res_valid, got);
      end
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      res_ready = 1'b0;
      clear_all();
      test_reset();
      test_single();
      test_both_fractions();
      test_scale_wrap();
      test_flags();
      test_round_robin();
      test_backpressure_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
